// File: rtl/axil_status_pkg.sv
// Purpose: shared constants, region type and word-address decode for axil_status_regs.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package axil_status_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_STAT,
        REG_FLAGS,
        REG_NONE
    } region_t;

    // Word map: CTRL words first, then STAT words, then the single FLAGS word.
    function automatic region_t decode_region(input int waddr, input int n_ctrl, input int n_stat);
        if (waddr < n_ctrl)                  return REG_CTRL;
        else if (waddr < n_ctrl + n_stat)    return REG_STAT;
        else if (waddr == n_ctrl + n_stat)   return REG_FLAGS;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/axil_status_regs_if.sv
// Purpose: AXI4-Lite bus bundle between the PS interconnect and axil_status_regs.
// Latency: none (wires only).
// Backpressure: standard AXI valid/ready on all five channels.
// Ports: aw*/w*/ar* driven by master, b*/r* and *ready driven by slave.
interface axil_status_regs_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH+1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH+1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_status_regs_stat_capture.sv
// Purpose: STAT capture registers, read-clear FLAGS word and optional snapshot shadow bank.
// Latency: stat_valid_i captures on the next edge; flags set/clear on the same edge.
// Backpressure: none; captures are unconditional.
// Ports: stat_in_i/stat_valid_i from fabric, flags_clr_i/snap_i from the read path,
//        stat_live_o/stat_shadow_o/flags_o to the read mux.
// Build option: AXIL_STATUS_SNAPSHOT_EN adds the shadow bank; otherwise shadow == live.
module stat_capture #(
    parameter int N_STAT     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_STAT*DATA_WIDTH-1:0] stat_in_i,
    input  logic [N_STAT-1:0]            stat_valid_i,
    input  logic                         flags_clr_i,
    input  logic                         snap_i,
    output logic [N_STAT*DATA_WIDTH-1:0] stat_live_o,
    output logic [N_STAT*DATA_WIDTH-1:0] stat_shadow_o,
    output logic [N_STAT-1:0]            flags_o
);
    logic [N_STAT*DATA_WIDTH-1:0] stat_q, stat_d;
    logic [N_STAT-1:0]            flags_q, flags_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < N_STAT; i++) begin
            if (stat_valid_i[i]) stat_d[i*DATA_WIDTH +: DATA_WIDTH] = stat_in_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
        // A FLAGS read returns every bit, so it clears them all; a same-edge capture still sets.
        flags_d = (flags_q & ~{N_STAT{flags_clr_i}}) | stat_valid_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= '0;
            flags_q <= '0;
        end else begin
            stat_q  <= stat_d;
            flags_q <= flags_d;
        end
    end

    assign stat_live_o = stat_q;
    assign flags_o     = flags_q;

`ifdef AXIL_STATUS_SNAPSHOT_EN
    logic [N_STAT*DATA_WIDTH-1:0] shadow_q, shadow_d;

    // Copy the pre-edge live values so the snapshot matches what STAT[0] returns.
    always_comb shadow_d = snap_i ? stat_q : shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end

    assign stat_shadow_o = shadow_q;
`else
    logic unused_snap;
    assign unused_snap   = snap_i;
    assign stat_shadow_o = stat_q;
`endif

endmodule

// File: rtl/axil_status_regs.sv
// Purpose: AXI4-Lite register slave with RW CTRL words, captured RO STAT words and a read-clear FLAGS word.
// Latency: write response 1 cycle after both AW and W are buffered; read data 1 cycle after AR accept.
// Backpressure: one-entry AW/W buffers, one write and one read outstanding; ready low until the response drains.
// Ports: axi_clock/rst, s_axil (slave modport), ctrl_out (N_CTRL words), stat_in/stat_valid (N_STAT words).
// Build option: AXIL_STATUS_SNAPSHOT_EN makes a STAT[0] read snapshot all STAT words for coherent reads.
module axil_status_regs
    import axil_status_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int N_CTRL     = 2,
    parameter int N_STAT     = 4
) (
    input  logic                         axi_clock,
    input  logic                         rst,
    axil_status_regs_if.slave            s_axil,
    output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_out,
    input  logic [N_STAT*DATA_WIDTH-1:0] stat_in,
    input  logic [N_STAT-1:0]            stat_valid
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] ctrl_q [N_CTRL];
    logic [DATA_WIDTH-1:0] ctrl_d [N_CTRL];

    logic [N_STAT*DATA_WIDTH-1:0] stat_live, stat_shadow;
    logic [N_STAT-1:0]            flags;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_exec;
    logic [ADDR_WIDTH-1:0] rd_addr;
    region_t wr_region, rd_region;

    assign aw_hs   = s_axil.awvalid && !aw_full_q;
    assign w_hs    = s_axil.wvalid && !w_full_q;
    assign b_hs    = bvalid_q && s_axil.bready;
    assign ar_hs   = s_axil.arvalid && !rvalid_q;
    assign r_hs    = rvalid_q && s_axil.rready;
    assign wr_exec = aw_full_q && w_full_q && !bvalid_q;

    assign rd_addr   = s_axil.araddr[ADDR_WIDTH+1:2];
    assign wr_region = decode_region(32'(aw_addr_q), N_CTRL, N_STAT);
    assign rd_region = decode_region(32'(rd_addr), N_CTRL, N_STAT);

    // Write path: buffers stay full until the response is taken, which blocks a second write.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil.awaddr[ADDR_WIDTH+1:2];
        end else if (b_hs) begin
            aw_full_d = 1'b0;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axil.wdata;
            w_strb_d = s_axil.wstrb;
        end else if (b_hs) begin
            w_full_d = 1'b0;
        end
        if (wr_exec) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_region == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < N_CTRL; k++) begin
                if (wr_region == REG_CTRL && 32'(aw_addr_q) == 32'(k)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_q[b]) ctrl_d[k][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path: data is sampled from pre-edge state, so same-edge writes/captures are not visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (rd_region)
                REG_CTRL: begin
                    for (int k = 0; k < N_CTRL; k++)
                        if (32'(rd_addr) == 32'(k)) rdata_d = ctrl_q[k];
                end
                REG_STAT: begin
                    // STAT[0] is always live; the others come from the (optional) shadow.
                    for (int i = 0; i < N_STAT; i++)
                        if (32'(rd_addr) == 32'(N_CTRL + i))
                            rdata_d = (i == 0) ? stat_live[i*DATA_WIDTH +: DATA_WIDTH]
                                               : stat_shadow[i*DATA_WIDTH +: DATA_WIDTH];
                end
                REG_FLAGS: rdata_d[N_STAT-1:0] = flags;
                default:   rresp_d = RESP_SLVERR;
            endcase
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
        end
    end

    stat_capture #(.N_STAT(N_STAT), .DATA_WIDTH(DATA_WIDTH)) u_stat (
        .clk           (axi_clock),
        .rst           (rst),
        .stat_in_i     (stat_in),
        .stat_valid_i  (stat_valid),
        .flags_clr_i   (ar_hs && rd_region == REG_FLAGS),
        .snap_i        (ar_hs && rd_region == REG_STAT && 32'(rd_addr) == 32'(N_CTRL)),
        .stat_live_o   (stat_live),
        .stat_shadow_o (stat_shadow),
        .flags_o       (flags)
    );

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end

    assign s_axil.awready = !aw_full_q;
    assign s_axil.wready  = !w_full_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = !rvalid_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    // prot and byte-offset address bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

endmodule

// File: tb/tb_axil_status_regs.sv
module tb_axil_status_regs;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NC = 2;
    localparam int NS = 4;
    localparam int W_FLAGS = NC + NS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC*DW-1:0] ctrl_out;
    logic [NS*DW-1:0] stat_in = '0;
    logic [NS-1:0]    stat_valid = '0;

    int checks = 0;
    int failures = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    axil_status_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_status_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CTRL(NC), .N_STAT(NS)) dut (
        .axi_clock  (clk),
        .rst        (rst),
        .s_axil     (bus),
        .ctrl_out   (ctrl_out),
        .stat_in    (stat_in),
        .stat_valid (stat_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares each response beat against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 32'(bus.bresp), 32'hFFFF_FFFF);
                else chk("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", bus.rdata, 32'hFFFF_FFFF);
                else begin
                    logic [33:0] e;
                    e = exp_r.pop_front();
                    chk("rdata", bus.rdata, e[31:0]);
                    chk("rresp", 32'(bus.rresp), 32'(e[33:32]));
                end
            end
        end
    end

    task automatic axi_write(input int word, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] er);
        int t;
        logic aw_go, w_go;
        @(posedge clk); #1;
        bus.awaddr = 8'(word * 4); bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        exp_b.push_back(er);
        t = 0;
        while ((bus.awvalid || bus.wvalid) && t < 50) begin
            @(negedge clk);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go)  bus.wvalid = 1'b0;
            t++;
        end
        if (bus.awvalid || bus.wvalid) begin
            chk("write_timeout", 32'd1, 32'd0);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        end
    endtask

    task automatic axi_read(input int word, input logic [31:0] ed, input logic [1:0] er);
        int t;
        @(posedge clk); #1;
        bus.araddr = 8'(word * 4); bus.arvalid = 1'b1;
        exp_r.push_back({er, ed});
        t = 0;
        @(negedge clk);
        while (!bus.arready && t < 50) begin @(negedge clk); t++; end
        if (!bus.arready) chk("read_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(bus.awready && bus.wready && bus.arready && !bus.bvalid && !bus.rvalid) && t < 100) begin
            @(negedge clk); t++;
        end
        if (t >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_stat(input logic [NS-1:0] mask, input logic [31:0] val);
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) if (mask[i]) stat_in[i*DW +: DW] = val;
        stat_valid = mask;
        @(posedge clk); #1;
        stat_valid = '0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready", 32'(bus.wready), 32'd1);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_ctrl0", ctrl_out[31:0], 32'd0);

        // Byte-strobed CTRL write
        axi_read(0, 32'h0, 2'b00);
        axi_write(0, 32'hDEAD_BEEF, 4'b0101, 2'b00);
        axi_read(0, 32'h00AD_00EF, 2'b00);
        wait_idle();
        chk("ctrl_out0", ctrl_out[31:0], 32'h00AD_00EF);

        // STAT capture and write protection
        pulse_stat(4'b0010, 32'h1234_5678);
        axi_write(NC + 1, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_read(NC, 32'h0, 2'b00);
        axi_read(NC + 1, 32'h1234_5678, 2'b00);

        // Unmapped word
        axi_read(63, 32'h0, 2'b10);
        axi_write(63, 32'h1111_1111, 4'hF, 2'b10);
        wait_idle();
        chk("unmapped_ctrl0", ctrl_out[31:0], 32'h00AD_00EF);
        chk("unmapped_ctrl1", ctrl_out[63:32], 32'h0);

        // FLAGS read-clear
        axi_read(W_FLAGS, 32'h2, 2'b00);
        pulse_stat(4'b0101, 32'h0000_0A0A);
        axi_read(W_FLAGS, 32'h5, 2'b00);
        axi_read(W_FLAGS, 32'h0, 2'b00);
        wait_idle();
        @(posedge clk); #1;
        bus.araddr = 8'(W_FLAGS * 4); bus.arvalid = 1'b1;
        stat_valid = 4'b0001;
        exp_r.push_back({2'b00, 32'h0});
        @(posedge clk); #1;
        bus.arvalid = 1'b0; stat_valid = '0;
        axi_read(W_FLAGS, 32'h1, 2'b00);

        // Read data held under rready backpressure
        wait_idle();
        bus.rready = 1'b0;
        axi_read(0, 32'h00AD_00EF, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
            chk("hold_rdata", bus.rdata, 32'h00AD_00EF);
            chk("hold_arready", 32'(bus.arready), 32'd0);
        end
        @(posedge clk); #1 bus.rready = 1'b1;

        // AW two cycles ahead of W
        wait_idle();
        @(posedge clk); #1;
        bus.awaddr = 8'(4); bus.awvalid = 1'b1;
        exp_b.push_back(2'b00);
        @(posedge clk); #1 bus.awvalid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1 bus.wvalid = 1'b0;
        @(negedge clk);
        chk("b_not_yet", 32'(bus.bvalid), 32'd0);
        @(negedge clk);
        chk("b_one_after_w", 32'(bus.bvalid), 32'd1);
        wait_idle();
        chk("ctrl_out1", ctrl_out[63:32], 32'h0BAD_F00D);

        // Same-edge write and read of a CTRL word: read sees the old value
        @(posedge clk); #1;
        bus.awaddr = 8'(0); bus.awvalid = 1'b1;
        bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        exp_b.push_back(2'b00);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 8'(0); bus.arvalid = 1'b1;
        exp_r.push_back({2'b00, 32'h00AD_00EF});
        @(posedge clk); #1 bus.arvalid = 1'b0;
        axi_read(0, 32'h1122_3344, 2'b00);

        // Snapshot coherence
        axi_read(NC, 32'h0000_0A0A, 2'b00);
        pulse_stat(4'b0010, 32'h0000_AAAA);
`ifdef AXIL_STATUS_SNAPSHOT_EN
        axi_read(NC + 1, 32'h1234_5678, 2'b00);
`else
        axi_read(NC + 1, 32'h0000_AAAA, 2'b00);
`endif
        wait_idle();

        // Reset mid-transaction drops the buffered write
        @(posedge clk); #1;
        bus.awaddr = 8'(4); bus.awvalid = 1'b1;
        bus.wdata = 32'h5555_5555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("arst_ctrl1", ctrl_out[63:32], 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_bvalid_after", 32'(bus.bvalid), 32'd0);
        chk("arst_awready", 32'(bus.awready), 32'd1);
        chk("arst_ctrl0", ctrl_out[31:0], 32'd0);

        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
        chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_status_regs.md
# axil_status_regs

Parametrised AXI4-Lite register slave for the GPS/timing designs: N_CTRL read/write control words drive fabric outputs, and N_STAT read-only status words are captured from fabric on per-channel valid strobes. It adds enforced write protection, SLVERR for illegal accesses, a read-clear update-flag word and an optional coherent multi-word snapshot. It sits between the PS AXI-Lite interconnect and blocks such as the NMEA decoder, which supplies time-of-day and subsecond status.

## Interface
- DATA_WIDTH, 32: AXI data width; must be 32.
- ADDR_WIDTH, 6: word-address bits; byte address is ADDR_WIDTH+2 bits.
- N_CTRL, 2: control words, 1..16.
- N_STAT, 4: status words, 1..16; N_CTRL+N_STAT+1 ≤ 2**ADDR_WIDTH.

Ports:
- axi_clock  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axil_aw{addr[ADDR_WIDTH+1:0],prot[2:0],valid} in / awready out: write address channel.
- s_axil_w{data[DATA_WIDTH-1:0],strb[DATA_WIDTH/8-1:0],valid} in / wready out: write data channel.
- s_axil_bresp[1:0], bvalid out / bready in: write response channel.
- s_axil_ar{addr,prot,valid} in / arready out: read address channel.
- s_axil_rdata[DATA_WIDTH-1:0], rresp[1:0], rvalid out / rready in: read data channel.
- ctrl_out  out  N_CTRL*DATA_WIDTH  control words; word k is bits [k*32+:32].
- stat_in  in  N_STAT*DATA_WIDTH  status inputs, same packing.
- stat_valid  in  N_STAT  per-channel capture strobe.

## Operation
- Word map: 0..N_CTRL-1 are CTRL (RW). N_CTRL..N_CTRL+N_STAT-1 are STAT (RO). FLAGS sits at N_CTRL+N_STAT (RO, read-clear). All higher words are unmapped. The address is taken from bits [ADDR_WIDTH+1:2]; byte-offset bits are ignored.
- Capture: stat_valid[i] loads stat_in word i into STAT[i] and sets FLAGS[i].
- Write: AW and W are accepted independently and each is held in a one-entry buffer. When both buffers are full and bvalid=0, the write executes:
  - CTRL target: byte lanes written per wstrb, bresp=OKAY.
  - STAT or FLAGS target: no change, bresp=SLVERR (2'b10).
  - Unmapped target: no change, bresp=SLVERR.
- Read: the address is accepted when arready=1. rdata/rresp are registered.
  - Mapped word: rresp=OKAY.
  - Unmapped word: rdata=0, rresp=SLVERR.
  - A FLAGS read returns the current flags and clears every returned bit on the accept edge.
- prot is ignored.

## Timing
- Reset values:
  - awready=wready=arready=1.
  - bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - CTRL=0, STAT=0, FLAGS=0.
- Write latency: the cycle after the second of AW/W is accepted, the register is updated and bvalid=1 on the same edge.
- awready drops after its beat is accepted and rises the cycle after bvalid&&bready; wready behaves the same way. At most one write is outstanding.
- Read latency: 1 cycle from the ar handshake to rvalid=1. arready=0 while rvalid=1, and rises the cycle after rvalid&&rready. rdata is stable while rvalid&&!rready.
- Simultaneous events:
  - A write and a read to the same CTRL word accepted on the same edge: the read returns the old value.
  - stat_valid[i] on the same edge a read of STAT[i] is accepted: the read returns the old value.
  - stat_valid[i] on the same edge a FLAGS read is accepted: the read returns the old bit, and the set wins (bit ends at 1).
- ctrl_out is register-driven with no combinational path from AXI inputs.
- Asserting rst mid-transaction aborts it immediately: in-flight responses are dropped and all state returns to reset values.

## Configuration
- AXIL_STATUS_SNAPSHOT_EN defined:
  - Accepting a read of STAT[0] copies all STAT words into a shadow bank on that edge.
  - Reads of STAT[1..N_STAT-1] return the shadow, giving a coherent multi-word read (e.g. time + subsec).
  - STAT[0] itself returns the live value.
  - The shadow resets to 0.
- Not defined: there is no shadow, and every STAT read returns the live register.

## Structure
- Package axil_status_pkg holds:
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - A region-type enum {REG_CTRL, REG_STAT, REG_FLAGS, REG_NONE}.
  - A decode function mapping word address to region.
- Sub-module stat_capture holds STAT, FLAGS and the optional shadow bank. Its inputs are stat_in/stat_valid plus read-clear and snapshot strobes; its outputs are the live and shadow words.

## Test plan
- After reset, read word 0 → rdata=0, OKAY. Write 0xDEADBEEF with strb=4'b0101 to word 0, then read → 0x00AD00EF and ctrl_out[31:0]=0x00AD00EF.
- Pulse stat_valid[1] with 0x12345678, then write 0xFFFFFFFF to word N_CTRL+1 → bresp=SLVERR; a read returns 0x12345678.
- Read word 63 (unmapped) → rdata=0, rresp=SLVERR. Write word 63 → SLVERR, with no CTRL change.
- Pulse stat_valid[0] and stat_valid[2], then read FLAGS → 0x5; read FLAGS again → 0x0. Pulse stat_valid[0] on the edge the FLAGS read is accepted → the read returns 0, and the next read returns 0x1.
- Hold rready=0 for 5 cycles → rvalid and rdata are stable and arready=0. Present AW two cycles before W → bvalid rises exactly one cycle after W is accepted.
- With AXIL_STATUS_SNAPSHOT_EN: read STAT[0], then pulse stat_valid[1]=0xAAAA, then read STAT[1] → the pre-pulse value. Without the macro → 0xAAAA.
